// File: rtl/ev_pkg.sv
// Shared EVState-side definitions: input-conditioning FSM encoding and default timing.
package ev_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HOLD     = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } ev_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES     = 8;
  localparam int unsigned DEF_REPEAT_CYCLES   = 3;
  localparam int unsigned DEF_REPEAT_EN       = 1;
  localparam int unsigned DEF_CNT_W           = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; both stages reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/increase_pulse_gen.sv
// Push-button conditioner: sync, debounce, edge-to-pulse and optional auto-repeat
// producing a registered single-cycle Increase strobe plus a debounced Held level.
module increase_pulse_gen
  import ev_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Btn,
  input  logic Enable,
  output logic Increase,
  output logic Held
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             bs;
  ev_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             increase_q, increase_d;
  logic             held_q, held_d;

  sync2 u_sync2 (
    .clk   (Clock),
    .rst_n (Reset),
    .d     (Btn),
    .q     (bs)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    increase_d = 1'b0;
    held_d     = held_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bs) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (!bs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d    = HOLD;
          increase_d = Enable & ~increase_q;
          held_d     = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // Release outranks a coincident hold/repeat tick, so no pulse on the way out.
      HOLD: begin
        if (!bs) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if ((REPEAT_EN != 0) && (cnt_q >= HOLD_LAST)) begin
          state_d    = REPEAT;
          increase_d = Enable & ~increase_q;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REPEAT: begin
        if (!bs) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (cnt_q >= REP_LAST) begin
          increase_d = Enable & ~increase_q;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REL_DB: begin
        if (bs) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = IDLE;
          held_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      increase_q <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      increase_q <= increase_d;
      held_q     <= held_d;
    end
  end

  assign Increase = increase_q;
  assign Held     = held_q;

endmodule

// File: tb/tb_increase_pulse_gen.sv
// Scoreboard bench: expected pulse edges are queued with the stimulus and matched on each Increase.
module tb_increase_pulse_gen;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Btn = 1'b0;
  logic Enable = 1'b1;
  logic Increase, Held;
  logic inc_nr, held_nr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base = 0;
  int exp_q[$];
  int exp_nr_q[$];
  bit inc_prev = 1'b0;
  bit inc_nr_prev = 1'b0;

  increase_pulse_gen dut (
    .Clock(Clock), .Reset(Reset), .Btn(Btn), .Enable(Enable),
    .Increase(Increase), .Held(Held)
  );

  increase_pulse_gen #(.REPEAT_EN(0)) dut_nr (
    .Clock(Clock), .Reset(Reset), .Btn(Btn), .Enable(Enable),
    .Increase(inc_nr), .Held(held_nr)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", tag, act, exp, cyc - base);
    end
  endtask

  // Pulse scoreboards for both instances.
  always @(negedge Clock) begin
    if (Increase) begin
      if (exp_q.size() == 0) chk("inc_spurious", cyc - base, -1);
      else                   chk("inc_edge", cyc - base, exp_q.pop_front());
      chk("inc_b2b", int'(inc_prev), 0);
    end
    if (inc_nr) begin
      if (exp_nr_q.size() == 0) chk("nr_inc_spurious", cyc - base, -1);
      else                      chk("nr_inc_edge", cyc - base, exp_nr_q.pop_front());
      chk("nr_inc_b2b", int'(inc_nr_prev), 0);
    end
    inc_prev    = Increase;
    inc_nr_prev = inc_nr;
  end

  task automatic at(input int e);
    while (cyc < base + e) @(negedge Clock);
  endtask

  task automatic start();
    Reset  = 1'b0;
    Btn    = 1'b0;
    Enable = 1'b1;
    repeat (3) @(negedge Clock);
    chk("rst_inc", Increase, 0);
    chk("rst_held", Held, 0);
    Reset = 1'b1;
    base  = cyc;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_missing"}, exp_q.size(), 0);
    chk({tag, "_nr_missing"}, exp_nr_q.size(), 0);
    exp_q.delete();
    exp_nr_q.delete();
  endtask

  initial begin
    // Clean press: Btn sampled high on edges 10..15.
    start();
    exp_q.push_back(16);
    exp_nr_q.push_back(16);
    at(9);  Btn = 1'b1;
    at(15); chk("clean_held_pre", Held, 0); Btn = 1'b0;
    at(16); chk("clean_held_on", Held, 1);
    at(21); chk("clean_held_reldb", Held, 1);
    at(22); chk("clean_held_off", Held, 0);
    at(30); drained("clean");

    // Bounce: alternating samples never debounce.
    start();
    for (int i = 0; i < 10; i++) begin
      at(9 + i);
      Btn = (i % 2 == 0);
      chk("bounce_held", Held, 0);
    end
    at(30); chk("bounce_held_end", Held, 0);
    drained("bounce");

    // Auto-repeat: held edges 10..39; no-repeat instance pulses once.
    start();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{16, 24, 27, 30, 33, 36, 39};
    exp_nr_q.push_back(16);
    at(9);  Btn = 1'b1;
    at(20); chk("rep_held", Held, 1); chk("rep_nr_held", held_nr, 1);
    at(39); Btn = 1'b0;
    at(60); chk("rep_held_end", Held, 0); chk("rep_nr_held_end", held_nr, 0);
    drained("repeat");

    // Enable gating: missed ticks are dropped, resume at 27.
    start();
    Enable = 1'b0;
    exp_q = '{27, 30, 33, 36, 39};
    at(9);  Btn = 1'b1;
    at(20); chk("en_held", Held, 1);
    at(24); Enable = 1'b1;
    at(39); Btn = 1'b0;
    at(60); drained("enable");

    // Async reset mid-hold, button still high after release.
    start();
    exp_q    = '{16, 29};
    exp_nr_q = '{16, 29};
    at(9);  Btn = 1'b1;
    at(20); chk("arst_held_pre", Held, 1);
    Reset = 1'b0;
    #1;
    chk("arst_held", Held, 0);
    chk("arst_inc", Increase, 0);
    at(22); Reset = 1'b1;
    at(28); chk("arst_held_redb", Held, 0);
    at(29); chk("arst_held_back", Held, 1);
    at(31); Btn = 1'b0;
    at(45); chk("arst_held_end", Held, 0);
    drained("arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
